// File: rtl/key_unlock_loader.sv
// key_unlock_loader
//   Delivery end of the logic-locking key interface. A serial key frame
//   (KEY_W key bits then 8 checksum bits, LSB first) is shifted in, the
//   checksum (XOR of all key bytes) is verified, and a good key is driven
//   onto the parallel key bus feeding the locked core's keyinput pins.
//   Consecutive checksum failures are counted; MAX_TRIES of them lock the
//   loader out until rst_n.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (sync release expected)
//   start      in   1-cycle pulse: begin or restart a key frame
//   key_sdi    in   serial frame bit
//   key_valid  in   key_sdi valid this cycle
//   key_ready  out  loader accepts a bit this cycle
//   key_out    out  [KEY_W-1:0] parallel key to the core
//   key_ok     out  key_out holds a checksum-verified key
//   done       out  1-cycle pulse: frame accepted and applied
//   err        out  1-cycle pulse: frame checksum mismatch
//   locked_out out  failure limit reached, dead until reset
//   tries      out  [$clog2(MAX_TRIES+1)-1:0] consecutive failure count
//
// Configuration macro
//   KEY_ZEROIZE_EN : when defined, a checksum failure also clears key_out
//                    and key_ok in the err cycle. Undefined: a failure
//                    leaves the last verified key in place.
//
// Handshake: a bit transfers on the rising edge where key_valid && key_ready.
// key_ready is high only while shifting; the source may hold or drop
// key_valid at will, there is no timeout.
//
// The FSM state is held in state_q (type state_t) for checker binding.

module key_unlock_loader #(
  parameter int KEY_W     = 24,
  parameter int MAX_TRIES = 3,
  localparam int TRIES_W  = $clog2(MAX_TRIES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               key_sdi,
  input  logic               key_valid,
  output logic               key_ready,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_ok,
  output logic               done,
  output logic               err,
  output logic               locked_out,
  output logic [TRIES_W-1:0] tries
);

  localparam int FRAME_W = KEY_W + 8;
  localparam int NBYTES  = KEY_W / 8;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CHECK   = 3'd2,
    APPLY   = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [KEY_W-1:0]   key_q;
  logic               key_ok_q;
  logic               done_q;
  logic               err_q;
  logic [TRIES_W-1:0] tries_q;

  logic [7:0]         chk_calc;
  logic               chk_match;
  logic               accept;
  logic               last_bit;
  logic               fail_limit;

  // Checksum over the key portion of the frame.
  always_comb begin
    chk_calc = '0;
    for (int i = 0; i < NBYTES; i++) begin
      chk_calc = chk_calc ^ frame_q[8*i +: 8];
    end
  end

  assign chk_match  = (chk_calc == frame_q[FRAME_W-1 -: 8]);
  assign accept     = key_valid && (state_q == SHIFT);
  assign last_bit   = (bit_cnt_q == CNT_W'(FRAME_W - 1));
  // This failure would be the one that reaches the limit.
  assign fail_limit = (tries_q >= TRIES_W'(MAX_TRIES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        // A restart has priority over a bit offered in the same cycle.
        if (!start && accept && last_bit) state_d = CHECK;
      end
      CHECK: begin
        if (chk_match)       state_d = APPLY;
        else if (fail_limit) state_d = LOCKOUT;
        else                 state_d = IDLE;
      end
      APPLY:   state_d = IDLE;
      LOCKOUT: state_d = LOCKOUT;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: shift register, counter, key bus, status pulses.
  // The verdict is registered at the end of CHECK so key_out, key_ok,
  // done/err and tries all become visible together two cycles after the
  // last accepted bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q   <= '0;
      bit_cnt_q <= '0;
      key_q     <= '0;
      key_ok_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tries_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) bit_cnt_q <= '0;
        end
        SHIFT: begin
          if (start) begin
            // Abort: discard the partial frame, not counted as a failure.
            bit_cnt_q <= '0;
          end else if (accept) begin
            // Shift right so the first bit ends up at bit 0.
            frame_q   <= {key_sdi, frame_q[FRAME_W-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        CHECK: begin
          if (chk_match) begin
            key_q    <= frame_q[KEY_W-1:0];
            key_ok_q <= 1'b1;
            done_q   <= 1'b1;
            tries_q  <= '0;
          end else begin
            err_q <= 1'b1;
            if (tries_q != TRIES_W'(MAX_TRIES)) tries_q <= tries_q + 1'b1;
            if (fail_limit) begin
              key_q    <= '0;
              key_ok_q <= 1'b0;
            end else begin
`ifdef KEY_ZEROIZE_EN
              key_q    <= '0;
              key_ok_q <= 1'b0;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign key_ready  = (state_q == SHIFT);
  assign key_out    = key_q;
  assign key_ok     = key_ok_q;
  assign done       = done_q;
  assign err        = err_q;
  assign locked_out = (state_q == LOCKOUT);
  assign tries      = tries_q;

endmodule

// File: tb/tb_key_unlock_loader.sv
// Bench for key_unlock_loader: directed key frames driven through tasks,
// a frame-level model that decides each frame's verdict from the checksum
// rule, and one compare process checking every output each cycle.

module tb_key_unlock_loader;

  localparam int KEY_W     = 24;
  localparam int MAX_TRIES = 3;
  localparam int TRIES_W   = $clog2(MAX_TRIES + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic key_sdi = 1'b0;
  logic key_valid = 1'b0;

  logic               key_ready;
  logic [KEY_W-1:0]   key_out;
  logic               key_ok;
  logic               done;
  logic               err;
  logic               locked_out;
  logic [TRIES_W-1:0] tries;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  key_unlock_loader #(.KEY_W(KEY_W), .MAX_TRIES(MAX_TRIES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_sdi    (key_sdi),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_out    (key_out),
    .key_ok     (key_ok),
    .done       (done),
    .err        (err),
    .locked_out (locked_out),
    .tries      (tries)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  logic [KEY_W-1:0] m_key_out = '0;
  logic             m_key_ok  = 1'b0;
  int               m_tries   = 0;
  logic             m_locked  = 1'b0;

  // One frame verdict pending at a time: frame content and the cycle its
  // result must show on the outputs.
  int               pend_cyc = -1;
  logic [KEY_W-1:0] pend_key = '0;
  logic [7:0]       pend_chk = '0;
  bit               check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_xor(input logic [KEY_W-1:0] k);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < KEY_W / 8; i++) r = r ^ k[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_key_out = '0;
    m_key_ok  = 1'b0;
    m_tries   = 0;
    m_locked  = 1'b0;
    pend_cyc  = -1;
  endtask

  // Compare process: every cycle, sampled on the falling edge.
  initial begin : compare
    logic exp_done;
    logic exp_err;
    forever begin
      @(negedge clk);
      if (check_en) begin
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (cyc == pend_cyc) begin
          if (byte_xor(pend_key) == pend_chk) begin
            exp_done  = 1'b1;
            m_key_out = pend_key;
            m_key_ok  = 1'b1;
            m_tries   = 0;
          end else begin
            exp_err = 1'b1;
            if (m_tries < MAX_TRIES) m_tries++;
            if (m_tries == MAX_TRIES) begin
              m_locked  = 1'b1;
              m_key_out = '0;
              m_key_ok  = 1'b0;
            end else begin
`ifdef KEY_ZEROIZE_EN
              m_key_out = '0;
              m_key_ok  = 1'b0;
`endif
            end
          end
          pend_cyc = -1;
        end
        check("done", 32'(done), 32'(exp_done));
        check("err", 32'(err), 32'(exp_err));
        check("key_out", 32'(key_out), 32'(m_key_out));
        check("key_ok", 32'(key_ok), 32'(m_key_ok));
        check("tries", 32'(tries), 32'(m_tries));
        check("locked_out", 32'(locked_out), 32'(m_locked));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive nbits of a frame LSB first. toggle inserts an idle cycle after
  // each bit. sched registers the verdict expected two cycles after the
  // cycle in which the last bit is offered.
  task automatic send_bits(input logic [KEY_W+7:0] frame, input int nbits,
                           input bit toggle, input bit sched);
    for (int i = 0; i < nbits; i++) begin
      key_sdi   = frame[i];
      key_valid = 1'b1;
      if (i == nbits - 1 && sched && !m_locked) begin
        pend_cyc = cyc + 2;
        pend_key = frame[KEY_W-1:0];
        pend_chk = frame[KEY_W+7:KEY_W];
      end
      tick();
      key_valid = 1'b0;
      if (toggle) begin
        key_sdi = ~key_sdi;
        tick();
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [KEY_W-1:0] key, input logic [7:0] chk,
                            input bit toggle);
    pulse_start();
    send_bits({chk, key}, KEY_W + 8, toggle, 1'b1);
    repeat (4) tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_key_out", 32'(key_out), 32'h0);
    check("rst_key_ok", 32'(key_ok), 32'h0);
    check("rst_key_ready", 32'(key_ready), 32'h0);
    check("rst_tries", 32'(tries), 32'h0);
    check("rst_locked", 32'(locked_out), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check_en = 1'b1;

    // 1: good frame
    pulse_start();
    @(negedge clk);
    check("t1_ready_in_shift", 32'(key_ready), 32'h1);
    tick();
    send_bits({8'h96, 24'hA53C0F}, KEY_W + 8, 1'b0, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    check("t1_key", 32'(key_out), 32'h00A53C0F);
    check("t1_key_ok", 32'(key_ok), 32'h1);
    check("t1_tries", 32'(tries), 32'h0);
    check("t1_ready_idle", 32'(key_ready), 32'h0);
    tick();

    // 2: bad checksum
    send_frame(24'hA53C0F, 8'h97, 1'b0);
    @(negedge clk);
    check("t2_tries", 32'(tries), 32'h1);
`ifdef KEY_ZEROIZE_EN
    check("t2_key", 32'(key_out), 32'h0);
`else
    check("t2_key", 32'(key_out), 32'h00A53C0F);
`endif
    check("t2_ready_idle", 32'(key_ready), 32'h0);
    tick();

    // 5: abort after 10 bits, then a full good frame
    pulse_start();
    send_bits({8'h70, 24'h123456}, 10, 1'b0, 1'b0);
    pulse_start();
    @(negedge clk);
    check("t5_tries_after_abort", 32'(tries), 32'h1);
    tick();
    send_bits({8'h70, 24'h123456}, KEY_W + 8, 1'b0, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    check("t5_key", 32'(key_out), 32'h00123456);
    check("t5_tries", 32'(tries), 32'h0);
    tick();

    // 4: two bad frames then a good one
    send_frame(24'h000001, 8'h00, 1'b0);
    send_frame(24'h000001, 8'hFF, 1'b0);
    @(negedge clk);
    check("t4_tries_two", 32'(tries), 32'h2);
    tick();
    send_frame(24'h000001, 8'h01, 1'b0);
    @(negedge clk);
    check("t4_key", 32'(key_out), 32'h00000001);
    check("t4_tries", 32'(tries), 32'h0);
    check("t4_locked", 32'(locked_out), 32'h0);
    tick();

    // 6: key_valid toggling during a good frame
    send_frame(24'hC3A55A, 8'h3C, 1'b1);
    @(negedge clk);
    check("t6_key", 32'(key_out), 32'h00C3A55A);
    check("t6_key_ok", 32'(key_ok), 32'h1);
    tick();

    // 6: reset mid-frame, after a failure so tries is nonzero
    send_frame(24'h0F0F0F, 8'h00, 1'b0);
    pulse_start();
    send_bits({8'h0F, 24'h0F0F0F}, 12, 1'b0, 1'b0);
    check_en = 1'b0;
    rst_n = 1'b0;
    #2;
    check("mid_rst_key_out", 32'(key_out), 32'h0);
    check("mid_rst_key_ok", 32'(key_ok), 32'h0);
    check("mid_rst_ready", 32'(key_ready), 32'h0);
    check("mid_rst_tries", 32'(tries), 32'h0);
    check("mid_rst_locked", 32'(locked_out), 32'h0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    check_en = 1'b1;
    send_frame(24'h000001, 8'h01, 1'b0);
    @(negedge clk);
    check("post_rst_key", 32'(key_out), 32'h00000001);
    tick();

    // 3: three bad frames -> lockout, then a good frame is ignored
    send_frame(24'h111111, 8'h00, 1'b0);
    send_frame(24'h222222, 8'h00, 1'b0);
    send_frame(24'h333333, 8'h00, 1'b0);
    @(negedge clk);
    check("t3_locked", 32'(locked_out), 32'h1);
    check("t3_key", 32'(key_out), 32'h0);
    check("t3_key_ok", 32'(key_ok), 32'h0);
    check("t3_ready", 32'(key_ready), 32'h0);
    check("t3_tries", 32'(tries), 32'h3);
    tick();
    send_frame(24'hA53C0F, 8'h96, 1'b0);
    @(negedge clk);
    check("t3_still_locked", 32'(locked_out), 32'h1);
    check("t3_key_after", 32'(key_out), 32'h0);
    tick();

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
